// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: DEPTH-entry prefetch FIFO feeding the instruction
// register, with conditional skip, sticky halt detection and branch flush.
// Optional feature: define IQ_BYPASS_EN to let a word arriving at an empty
// queue go straight into the IR when an issue request coincides with it.
module instr_prefetch_queue #(
  parameter int                DATA_W     = 16,
  parameter int                DEPTH      = 2,
  parameter int                SKIP_BIT   = 13,
  parameter logic [DATA_W-1:0] HALT_MASK  = 16'hD800,
  parameter logic [DATA_W-1:0] HALT_MATCH = 16'hD800,
  parameter logic [DATA_W-1:0] NOP_WORD   = 16'h0000
) (
  input  logic                       clk_in,
  input  logic                       reset_n_in,
  input  logic                       fetch_valid_in,
  input  logic [DATA_W-1:0]          fetch_data_in,
  output logic                       fetch_ready_out,
  input  logic                       issue_en_in,
  input  logic                       cond_in,
  input  logic                       flush_in,
  output logic [DATA_W-1:0]          ir_data_out,
  output logic                       ir_valid_out,
  output logic                       halted_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;

  logic              run, halt_hit, issue_ok, push, empty;
  logic              bypass, pop, write, skip;
  logic [DATA_W-1:0] sel;

  // Handshake, halt detection and pop/bypass decisions for this cycle
  always_comb begin
    run             = (state == RUN);
    fetch_ready_out = run && (count != FULL) && !flush_in;
    halt_hit        = run && ir_valid && ((ir & HALT_MASK) == HALT_MATCH)
                      && issue_en_in && !flush_in;
    issue_ok        = run && issue_en_in && !flush_in && !halt_hit;
    push            = fetch_valid_in && fetch_ready_out;
    empty           = (count == '0);
`ifdef IQ_BYPASS_EN
    bypass          = issue_ok && empty && push;
`else
    bypass          = 1'b0;
`endif
    pop             = issue_ok && !empty;
    write           = push && !bypass;
    sel             = bypass ? fetch_data_in : mem[rd_ptr];
    skip            = sel[SKIP_BIT] && cond_in;
  end

  // Queue storage; written at the tail only when the word is not bypassed
  always_ff @(posedge clk_in) begin
    if (reset_n_in && write)
      mem[wr_ptr] <= fetch_data_in;
  end

  // RUN/HALT state, pointers, occupancy and IR; flush outranks issue and push
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state    <= RUN;
      ir       <= NOP_WORD;
      ir_valid <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (run) begin
      if (flush_in) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        ir       <= NOP_WORD;
        ir_valid <= 1'b0;
      end else begin
        if (halt_hit) begin
          state    <= HALT;
          ir       <= NOP_WORD;
          ir_valid <= 1'b0;
        end else if (issue_ok) begin
          if (pop || bypass) begin
            ir       <= skip ? NOP_WORD : sel;
            ir_valid <= !skip;
          end else begin
            ir       <= NOP_WORD;
            ir_valid <= 1'b0;
          end
        end
        if (write) wr_ptr <= wr_ptr + PW'(1);
        if (pop)   rd_ptr <= rd_ptr + PW'(1);
        if (write && !pop)      count <= count + CW'(1);
        else if (!write && pop) count <= count - CW'(1);
      end
    end
  end

  assign ir_data_out  = ir;
  assign ir_valid_out = ir_valid;
  assign halted_out   = (state == HALT);
  assign count_out    = count;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Testbench for instr_prefetch_queue: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_instr_prefetch_queue;

  localparam int DEPTH = 2;
  localparam logic [15:0] HMASK  = 16'hD800;
  localparam logic [15:0] HMATCH = 16'hD800;
`ifdef IQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, fv, issue, cond, flush;
  logic [15:0] fd;
  logic        fetch_ready;
  logic [15:0] ir;
  logic        irv, halted;
  logic [1:0]  cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] mq[$];
  logic [15:0] mir;
  bit          mval, mhalt;

  always #5 clk = ~clk;

  instr_prefetch_queue #(.DATA_W(16), .DEPTH(DEPTH)) dut (
    .clk_in(clk), .reset_n_in(reset_n), .fetch_valid_in(fv),
    .fetch_data_in(fd), .fetch_ready_out(fetch_ready), .issue_en_in(issue),
    .cond_in(cond), .flush_in(flush), .ir_data_out(ir), .ir_valid_out(irv),
    .halted_out(halted), .count_out(cnt)
  );

  function automatic void model_load(input logic [15:0] w);
    if (w[13] && cond) begin mir = 16'h0000; mval = 1'b0; end
    else begin mir = w; mval = 1'b1; end
  endfunction

  function automatic bit model_ready();
    return !mhalt && (mq.size() < DEPTH) && !flush;
  endfunction

  // advance the model with the current inputs, then clock the DUT
  task automatic tick();
    bit push;
    logic [15:0] w;
    if (!reset_n) begin
      mq.delete(); mir = 16'h0000; mval = 1'b0; mhalt = 1'b0;
    end else if (!mhalt && flush) begin
      mq.delete(); mir = 16'h0000; mval = 1'b0;
    end else if (!mhalt) begin
      push = fv && (mq.size() < DEPTH);
      if (issue && mval && ((mir & HMASK) == HMATCH)) begin
        mhalt = 1'b1; mir = 16'h0000; mval = 1'b0;
      end else if (issue && mq.size() > 0) begin
        w = mq.pop_front();
        model_load(w);
      end else if (issue && push && BYPASS) begin
        model_load(fd);
        push = 1'b0;
      end else if (issue) begin
        mir = 16'h0000; mval = 1'b0;
      end
      if (push) mq.push_back(fd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fv = 0; issue = 0; cond = 0; flush = 0; fd = '0;
  endtask

  task automatic push_word(input logic [15:0] w);
    idle(); fv = 1; fd = w; tick(); idle();
  endtask

  task automatic issue_once(input bit c);
    idle(); issue = 1; cond = c; tick(); idle();
  endtask

  task automatic test_reset();
    idle(); reset_n = 0;
    tick(); tick();
    reset_n = 1; #1;
    checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir got %h want 0000", ir); end
    checks++; if (irv !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", irv); end
    checks++; if (cnt !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", cnt); end
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", fetch_ready); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
  endtask

  task automatic test_fill_drain();
    push_word(16'h1234); push_word(16'h2345); #1;
    checks++; if (cnt !== 2'd2) begin errors++; $display("FAIL full_count got %0d want 2", cnt); end
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", fetch_ready); end
    issue_once(0);
    checks++; if (ir !== 16'h1234 || irv !== 1'b1) begin errors++; $display("FAIL drain_ir1 got %h/%b want 1234/1", ir, irv); end
    issue_once(0);
    checks++; if (ir !== 16'h2345 || irv !== 1'b1) begin errors++; $display("FAIL drain_ir2 got %h/%b want 2345/1", ir, irv); end
    checks++; if (cnt !== 2'd0) begin errors++; $display("FAIL drain_count got %0d want 0", cnt); end
  endtask

  task automatic test_skip();
    push_word(16'h2001); issue_once(1);
    checks++; if (ir !== 16'h0000 || irv !== 1'b0) begin errors++; $display("FAIL skip_taken got %h/%b want 0000/0", ir, irv); end
    checks++; if (cnt !== 2'd0) begin errors++; $display("FAIL skip_count got %0d want 0", cnt); end
    push_word(16'h2001); issue_once(0);
    checks++; if (ir !== 16'h2001 || irv !== 1'b1) begin errors++; $display("FAIL skip_not_taken got %h/%b want 2001/1", ir, irv); end
  endtask

  task automatic test_halt();
    push_word(16'hD800); issue_once(0);
    checks++; if (ir !== 16'hD800 || irv !== 1'b1) begin errors++; $display("FAIL halt_load got %h/%b want d800/1", ir, irv); end
    push_word(16'h1111);
    issue_once(0);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b want 1", halted); end
    checks++; if (ir !== 16'h0000 || irv !== 1'b0) begin errors++; $display("FAIL halt_ir got %h/%b want 0000/0", ir, irv); end
    checks++; if (cnt !== 2'd1) begin errors++; $display("FAIL halt_nopop got %0d want 1", cnt); end
    fv = 1; fd = 16'h5555; issue = 1; #1;
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL halt_ready got %b want 0", fetch_ready); end
    tick(); flush = 1; tick(); idle();
    checks++; if (cnt !== 2'd1 || ir !== 16'h0000 || halted !== 1'b1) begin
      errors++; $display("FAIL halt_sticky got cnt=%0d ir=%h h=%b want 1/0000/1", cnt, ir, halted);
    end
    reset_n = 0; tick(); reset_n = 1;
    checks++; if (halted !== 1'b0 || cnt !== 2'd0) begin errors++; $display("FAIL halt_reset got h=%b cnt=%0d want 0/0", halted, cnt); end
  endtask

  task automatic test_flush();
    push_word(16'h0AAA); push_word(16'h0BBB);
    fv = 1; fd = 16'h0CCC; issue = 1; flush = 1; #1;
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", fetch_ready); end
    tick(); idle();
    checks++; if (cnt !== 2'd0 || ir !== 16'h0000 || irv !== 1'b0) begin
      errors++; $display("FAIL flush_state got cnt=%0d ir=%h v=%b want 0/0000/0", cnt, ir, irv);
    end
    issue_once(0);
    checks++; if (ir !== 16'h0000 || irv !== 1'b0) begin errors++; $display("FAIL flush_dropped got %h/%b want 0000/0", ir, irv); end
  endtask

  task automatic test_bypass();
    logic [15:0] eir;
    logic [1:0]  ecnt;
    eir  = BYPASS ? 16'h4321 : 16'h0000;
    ecnt = BYPASS ? 2'd0 : 2'd1;
    idle(); fv = 1; fd = 16'h4321; issue = 1; tick(); idle();
    checks++; if (ir !== eir) begin errors++; $display("FAIL bypass_ir got %h want %h", ir, eir); end
    checks++; if (cnt !== ecnt) begin errors++; $display("FAIL bypass_count got %0d want %0d", cnt, ecnt); end
    reset_n = 0; tick(); reset_n = 1;
  endtask

  task automatic test_random();
    bit er;
    for (int i = 0; i < 600; i++) begin
      reset_n = ($urandom_range(0, 39) != 0);
      fv      = $urandom_range(0, 1);
      fd      = 16'($urandom);
      issue   = $urandom_range(0, 1);
      cond    = $urandom_range(0, 1);
      flush   = ($urandom_range(0, 9) == 0);
      #1;
      er = model_ready();
      checks++; if (fetch_ready !== er) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, fetch_ready, er); end
      tick();
      checks++; if (ir !== mir || irv !== mval) begin errors++; $display("FAIL rnd_ir cyc %0d got %h/%b want %h/%b", i, ir, irv, mir, mval); end
      checks++; if (halted !== mhalt) begin errors++; $display("FAIL rnd_halt cyc %0d got %b want %b", i, halted, mhalt); end
      checks++; if (cnt !== 2'(mq.size())) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, cnt, mq.size()); end
    end
  endtask

  initial begin
    reset_n = 0; mir = '0; mval = 0; mhalt = 0;
    idle();
    test_reset();
    test_fill_drain();
    test_skip();
    test_halt();
    test_flush();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Parametrised successor of the CPU's instruction register: a DEPTH-entry prefetch FIFO feeding a DATA_W-bit instruction register (IR). It sits between the fetch unit and the decoder. It accepts fetched words through a valid/ready handshake and loads the IR on each issue request. It applies the skip-next condition, detects the halt instruction and enters a sticky halted state, and supports a branch flush.

## Interface
- DATA_W, 16, instruction width.
- DEPTH, 2, FIFO entries; power of two, ≥2.
- SKIP_BIT, 13, instruction bit that marks a conditional-skip candidate.
- HALT_MASK, 16'hD800, bits compared for halt detection.
- HALT_MATCH, 16'hD800, halt pattern under HALT_MASK.
- NOP_WORD, 16'h0000, value loaded into the IR for a bubble.
- clk_in  input  1  single clock; all state updates on the rising edge.
- reset_n_in  input  1  synchronous, active-low reset.
- fetch_valid_in  input  1  fetch word present.
- fetch_data_in  input  DATA_W  fetched instruction.
- fetch_ready_out  output  1  queue can accept this cycle.
- issue_en_in  input  1  decoder requests the next instruction.
- cond_in  input  1  skip condition from the ALU flags.
- flush_in  input  1  branch taken; discard all queued words.
- ir_data_out  output  DATA_W  current IR.
- ir_valid_out  output  1  IR holds a real instruction (0 = bubble).
- halted_out  output  1  halt state.
- count_out  output  $clog2(DEPTH+1)  queued entries.

## Operation
- States: RUN and HALT. Reset enters RUN.
- Reset values: ir_data_out=NOP_WORD, ir_valid_out=0, halted_out=0, count_out=0, queue empty.
- fetch_ready_out = (state==RUN) & (count<DEPTH) & !flush_in. This is combinational.
- Push occurs when fetch_valid_in & fetch_ready_out. The word is written at the tail.
- Pop occurs when issue_en_in & state==RUN & !flush_in & count>0. The head word is removed, and the IR update depends on the skip check:
  - If head[SKIP_BIT] & cond_in: IR←NOP_WORD and ir_valid←0. The entry is consumed, so the instruction is skipped.
  - Otherwise: IR←head and ir_valid←1.
- Issue with an empty queue loads IR←NOP_WORD and ir_valid←0. This behaviour changes only when IQ_BYPASS_EN is defined.
- Push and pop in the same cycle: count is unchanged. Both pointers advance and wrap modulo DEPTH.
- Halt detection: in RUN, if ir_valid_out & ((ir_data_out & HALT_MASK)==HALT_MATCH) & issue_en_in, then:
  - the state moves to HALT;
  - IR←NOP_WORD and ir_valid←0;
  - no pop occurs.
- HALT is sticky until reset:
  - issue is ignored and pushes are refused;
  - the queue contents are frozen;
  - IR stays NOP_WORD.
- Flush has priority over issue and push. It clears the pointers (count←0), sets IR←NOP_WORD and ir_valid←0. Flush in HALT is ignored.
- Reset asserted mid-operation overrides every other input on that edge.

## Timing
- The IR updates on the rising edge of the cycle in which issue_en_in is sampled high.
- Push→IR minimum latency without bypass: 2 edges (store edge, then issue edge).
- halted_out rises on the edge that consumes the halt instruction's issue cycle.
- count_out reflects the push/pop result one edge later and is registered.

## Configuration
- IQ_BYPASS_EN defined: when count==0, a push and an issue in the same cycle (RUN, no flush) load fetch_data_in directly into the IR. The queue is not written and count stays 0. The skip check applies to fetch_data_in. Push→IR latency becomes 1 edge.
- IQ_BYPASS_EN undefined: the IR loads NOP_WORD and the word is queued.

## Test plan
- Reset with reset_n_in=0 for 2 cycles → ir_data_out=0x0000, ir_valid_out=0, count_out=0, fetch_ready_out=1.
- Push 0x1234, 0x2345 with no issue → count_out=2 and fetch_ready_out=0. Issue twice → IR=0x1234, then 0x2345, then count_out=0.
- Push 0x2001 (bit13 set), then issue with cond_in=1 → IR=0x0000 and ir_valid=0. The same word with cond_in=0 → IR=0x2001.
- IR=0xD800 valid, then issue_en_in=1 → halted_out=1 and IR=0x0000. Further pushes are refused and issues are ignored until reset.
- Two entries queued, then flush_in with fetch_valid_in and issue_en_in high → count_out=0, IR=0x0000, and the pushed word is dropped.
- Empty queue with simultaneous push 0x4321 and issue → IR=0x4321 with IQ_BYPASS_EN defined. Without it: IR=0x0000 and count_out=1.
